uart_hex_printer: RTL and testbench

UART_HEX_PRINTER -- requirements
Module: uart_hex_printer

---
 rtl/uart_hex_printer.sv | 94 +++++++++
 tb/tb_uart_hex_printer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_printer.sv
// Prints a value as NIBBLES uppercase hex ASCII characters over a valid/ready byte stream.
// Define UART_HEX_PRINTER_CRLF_EN to append CR LF after the digits.
module uart_hex_printer #(
  parameter int NIBBLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value_i,
  input  logic        printf_i,
  input  logic        tx_data_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_data_valid_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int ALIGN = 32 - 4 * NIBBLES;
`ifdef UART_HEX_PRINTER_CRLF_EN
  localparam logic [3:0] LAST = 4'(NIBBLES + 1);
`else
  localparam logic [3:0] LAST = 4'(NIBBLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state;
  logic [31:0] shift_reg;
  logic [3:0]  cnt;
  logic [31:0] value_aligned;
  logic [7:0]  cur_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // The active digit always sits in the top nibble, whatever NIBBLES is.
  assign value_aligned = value_i << ALIGN;

  always_comb begin
    cur_char = hex_char(shift_reg[31:28]);
    if (cnt == 4'(NIBBLES))
      cur_char = 8'h0D;
    else if (cnt > 4'(NIBBLES))
      cur_char = 8'h0A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift_reg       <= '0;
      cnt             <= '0;
      tx_data_o       <= '0;
      tx_data_valid_o <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (printf_i) begin
            shift_reg       <= value_aligned;
            cnt             <= '0;
            tx_data_o       <= hex_char(value_aligned[31:28]);
            tx_data_valid_o <= 1'b1;
            busy_o          <= 1'b1;
            state           <= SEND;
          end
        end
        SEND: begin
          if (tx_data_ready_i) begin
            tx_data_valid_o <= 1'b0;
            if (cnt == LAST) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= IDLE;
            end else begin
              cnt       <= cnt + 4'd1;
              shift_reg <= shift_reg << 4;
              state     <= GAP;
            end
          end
        end
        GAP: begin
          // cnt and shift_reg already point at the next character here.
          tx_data_o       <= cur_char;
          tx_data_valid_o <= 1'b1;
          state           <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_printer.sv
// Scoreboard bench for uart_hex_printer: a driver queues expected characters, monitors pop and compare.
module tb_uart_hex_printer;

  localparam int N = 8;
`ifdef UART_HEX_PRINTER_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = '0;
  logic        printf_r = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  logic [31:0] value2 = '0;
  logic        printf2 = 1'b0;
  logic        ready2 = 1'b1;
  logic [7:0]  tx_data2;
  logic        tx_valid2, busy2, done2;

  always #5 clk = ~clk;

  uart_hex_printer #(.NIBBLES(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .value_i(value), .printf_i(printf_r),
    .tx_data_ready_i(ready), .tx_data_o(tx_data), .tx_data_valid_o(tx_valid),
    .busy_o(busy), .done_o(done)
  );

  uart_hex_printer #(.NIBBLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .value_i(value2), .printf_i(printf2),
    .tx_data_ready_i(ready2), .tx_data_o(tx_data2), .tx_data_valid_o(tx_valid2),
    .busy_o(busy2), .done_o(done2)
  );

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];   // {last, byte}
  logic [8:0] exp2_q[$];
  int xfers = 0;
  int dones = 0;
  int dones2 = 0;
  int ready_mode = 0;     // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] digit_char(input logic [31:0] v, input int i);
    int d;
    d = int'((v >> (4 * i)) & 32'hF);
    return (d < 10) ? 8'(48 + d) : 8'(55 + d);
  endfunction

  function automatic void push_print(input logic [31:0] v);
    for (int i = N - 1; i >= 0; i--)
      exp_q.push_back({(!CRLF && i == 0), digit_char(v, i)});
    if (CRLF) begin
      exp_q.push_back({1'b0, 8'h0D});
      exp_q.push_back({1'b1, 8'h0A});
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = ($urandom % 4) != 0;
        default: ready = 1'b0;
      endcase
    end
  end

  // Main monitor: character order, gap cycle, stall stability, done pulse.
  initial begin
    logic pend_done, pend_gap, pend_resume, stall;
    logic d, g, r, s;
    logic [7:0] held;
    logic [8:0] e;
    pend_done = 0; pend_gap = 0; pend_resume = 0; stall = 0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_done = 0; pend_gap = 0; pend_resume = 0; stall = 0;
      end else begin
        d = pend_done; g = pend_gap; r = pend_resume; s = stall;
        pend_done = 0; pend_gap = 0; pend_resume = 0; stall = 0;
        check("done_pulse", done, d);
        if (d) begin
          dones++;
          check("idle_busy", busy, 0);
          check("idle_valid", tx_valid, 0);
        end
        if (g) begin
          check("gap_valid", tx_valid, 0);
          check("gap_busy", busy, 1);
          pend_resume = 1;
        end
        if (r) check("resume_valid", tx_valid, 1);
        if (s) begin
          check("stall_valid", tx_valid, 1);
          check("stall_data", tx_data, held);
        end
        if (tx_valid && ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            check("unexpected_char", tx_data, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("char", tx_data, e[7:0]);
            if (e[8]) pend_done = 1;
            else pend_gap = 1;
          end
        end else if (tx_valid) begin
          stall = 1;
          held = tx_data;
        end
      end
    end
  end

  // Monitor for the two-digit instance, which always has ready=1.
  initial begin
    logic pd2;
    logic [8:0] e;
    pd2 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pd2 = 0;
      end else begin
        check("done2_pulse", done2, pd2);
        if (pd2) dones2++;
        pd2 = 0;
        if (tx_valid2) begin
          if (exp2_q.size() == 0) begin
            check("unexpected_char2", tx_data2, 32'hFFFF_FFFF);
          end else begin
            e = exp2_q.pop_front();
            check("char2", tx_data2, e[7:0]);
            pd2 = e[8];
          end
        end
      end
    end
  end

  task automatic start_print(input logic [31:0] v);
    @(posedge clk);
    #1;
    value = v;
    printf_r = 1'b1;
    push_print(v);
    @(posedge clk);
    #1;
    printf_r = 1'b0;
    value = $urandom;
    @(negedge clk);
    check("first_char_latency", tx_valid, 1);
    check("busy_during_print", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = dones;
    for (int i = 0; i < budget && dones == start; i++) @(posedge clk);
    check("done_seen", dones > start, 1);
    #1;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (xfers >= target) break;
    end
    check("xfer_progress", xfers >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, d0;
    logic [31:0] v;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", tx_data, 0);
    check("reset_valid", tx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;

    // Known pattern with full-rate ready.
    ready_mode = 0;
    start_print(32'h1234ABCD);
    wait_done(200);

    // Back-pressure on the third character.
    start_print(32'h13579BDF);
    base = xfers - 0;
    wait_xfers(base + 2, 200);
    #1;
    ready_mode = 2;
    repeat (20) @(posedge clk);
    #1;
    ready_mode = 0;
    wait_done(200);

    // Requests during a print are ignored.
    start_print(32'h00000000);
    repeat (3) @(posedge clk);
    #1;
    value = 32'hFFFFFFFF;
    printf_r = 1'b1;
    @(posedge clk);
    #1;
    printf_r = 1'b0;
    @(negedge clk);
    check("busy_after_repulse", busy, 1);
    wait_done(200);

    // printf held high across done: second print starts after exactly one idle cycle.
    @(posedge clk);
    #1;
    value = 32'hDEADBEEF;
    printf_r = 1'b1;
    push_print(32'hDEADBEEF);
    @(posedge clk);
    #1;
    value = 32'h0C0FFEE9;
    push_print(32'h0C0FFEE9);
    d0 = dones;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (dones > d0) break;
    end
    #1;
    printf_r = 1'b0;
    @(negedge clk);
    check("b2b_restart_valid", tx_valid, 1);
    wait_done(200);

    // Random values under random back-pressure, with stray requests.
    ready_mode = 1;
    for (int k = 0; k < 12; k++) begin
      v = $urandom;
      start_print(v);
      if ($urandom % 2) begin
        @(posedge clk);
        #1;
        printf_r = 1'b1;
        value = $urandom;
        @(posedge clk);
        #1;
        printf_r = 1'b0;
      end
      wait_done(600);
    end
    ready_mode = 0;

    // Reset during the fourth character aborts the print.
    start_print(32'h0F0F0F0F);
    base = xfers;
    wait_xfers(base + 3, 200);
    @(posedge clk);
    #1;
    d0 = dones;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_data", tx_data, 0);
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check("no_done_after_abort", dones, d0);
    start_print(32'hA5A5A5A5);
    wait_done(200);

    // Two-digit instance uses only the low byte.
    @(posedge clk);
    #1;
    value2 = 32'hFFFFFF05;
    printf2 = 1'b1;
    exp2_q.push_back({1'b0, 8'h30});
    if (CRLF) begin
      exp2_q.push_back({1'b0, 8'h35});
      exp2_q.push_back({1'b0, 8'h0D});
      exp2_q.push_back({1'b1, 8'h0A});
    end else begin
      exp2_q.push_back({1'b1, 8'h35});
    end
    @(posedge clk);
    #1;
    printf2 = 1'b0;
    value2 = $urandom;
    d0 = dones2;
    for (int i = 0; i < 100 && dones2 == d0; i++) @(posedge clk);
    check("done2_seen", dones2 > d0, 1);

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("queue2_drained", exp2_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
